// File: rtl/lamp_fpu_addsub_pipe.sv
// lamp_fpu_addsub_pipe: two-stage floating-point add/sub core producing a pre-rounding result with G,R,S bits.
// Latency 2 cycles from accept to out_valid_o, 1 beat/cycle sustained, order preserved.
// Backpressure: stages advance only when their successor is empty or advancing; in_ready_o falls when both are held.
// Optional build macro LAMP_FPU_ADDSUB_FTZ_EN: flush-to-zero of denormal inputs and results.
module lamp_fpu_addsub_pipe #(
  parameter int E_DW   = 8,
  parameter int F_DW   = 7,
  parameter int TAG_DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              isOpSub_i,
  input  logic              s_op1_i,
  input  logic              s_op2_i,
  input  logic [F_DW:0]     extF_op1_i,
  input  logic [F_DW:0]     extF_op2_i,
  input  logic [E_DW:0]     extE_op1_i,
  input  logic [E_DW:0]     extE_op2_i,
  input  logic              isInf_op1_i,
  input  logic              isSNAN_op1_i,
  input  logic              isQNAN_op1_i,
  input  logic              isInf_op2_i,
  input  logic              isSNAN_op2_i,
  input  logic              isQNAN_op2_i,
  input  logic [TAG_DW-1:0] tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              s_res_o,
  output logic [E_DW-1:0]   e_res_o,
  output logic [F_DW+4:0]   f_res_o,
  output logic              isOverflow_o,
  output logic              isUnderflow_o,
  output logic              isInvalid_o,
  output logic              isToRound_o,
  output logic [TAG_DW-1:0] tag_o
);

  // Mantissa working width: {ovf, hidden, fraction, G, R, S}
  localparam int MW  = F_DW + 5;
  localparam int EW  = E_DW + 1;
  localparam int LZW = $clog2(MW);

  localparam logic [E_DW-1:0] E_MAX     = {E_DW{1'b1}};
  // Once the exponent gap reaches this, every bit of the smaller mantissa is below S
  localparam logic [EW-1:0]   ALIGN_LIM = EW'(MW - 1);
  // Canonical quiet NaN mantissa: hidden clear, fraction MSB set, GRS clear
  localparam logic [MW-1:0]   QNAN_F    = {2'b00, 1'b1, {(MW-3){1'b0}}};

  // Stage-1 register contents: aligned sum plus everything stage 2 needs
  typedef struct packed {
    logic              sign;
    logic [E_DW-1:0]   e;
    logic [MW-1:0]     f;
    logic [LZW-1:0]    lzc;
    logic              do_sub;
    logic              nan;
    logic              snan;
    logic              inf_inf;
    logic              inf;
    logic              inf_sign;
    logic [TAG_DW-1:0] tag;
  } s1_t;

  // Stage-2 (output) register contents
  typedef struct packed {
    logic              s;
    logic [E_DW-1:0]   e;
    logic [MW-1:0]     f;
    logic              ovf;
    logic              unf;
    logic              inv;
    logic              rnd;
    logic [TAG_DW-1:0] tag;
  } res_t;

  logic          s1_valid_q, s1_valid_d;
  s1_t           s1_q, s1_d, s1_calc;
  logic          out_valid_q, out_valid_d;
  res_t          res_q, res_d, res_calc;
  logic          s2_advance;

  // Stage-1 datapath temporaries
  logic [E_DW:0]   e1, e2, big_e, sml_e;
  logic [F_DW:0]   f1, f2, big_f, sml_f;
  logic            op1_gt;
  logic [EW-1:0]   e_diff;
  logic [MW-1:0]   big_m, sml_m, sml_sh, sml_al, sum;
  logic [2*MW-1:0] sh_wide;
  logic            sticky, do_sub, s2_eff;

  // Stage-2 datapath temporaries
  logic            n_s, n_ovf, n_unf, n_inv, n_rnd;
  logic [E_DW-1:0] n_e, lsh;
  logic [MW-1:0]   n_f;

  // Leading zeros of the bits below the overflow position, counted from the hidden bit
  function automatic logic [LZW-1:0] lzc_f(input logic [MW-2:0] v);
    logic [LZW-1:0] n;
    n = LZW'(MW - 1);
    for (int i = 0; i < MW - 1; i++) begin
      if (v[i]) n = LZW'(MW - 2 - i);
    end
    return n;
  endfunction

  // Stage 1: magnitude compare, align the smaller operand, add/subtract, count leading zeros
  always_comb begin
    e1 = extE_op1_i;
    e2 = extE_op2_i;
    f1 = extF_op1_i;
    f2 = extF_op2_i;
`ifdef LAMP_FPU_ADDSUB_FTZ_EN
    // Denormal inputs collapse to a zero of the same sign
    if (e1 == '0) f1 = '0;
    if (e2 == '0) f2 = '0;
`endif
    op1_gt = {e1, f1} >= {e2, f2};
    if (op1_gt) begin
      big_e = e1; big_f = f1; sml_e = e2; sml_f = f2;
    end else begin
      big_e = e2; big_f = f2; sml_e = e1; sml_f = f1;
    end
    e_diff  = big_e - sml_e;
    big_m   = {1'b0, big_f, 3'b000};
    sml_m   = {1'b0, sml_f, 3'b000};
    sh_wide = {sml_m, {MW{1'b0}}} >> e_diff;
    if (e_diff >= ALIGN_LIM) begin
      sml_sh = '0;
      sticky = |sml_m;
    end else begin
      sml_sh = sh_wide[2*MW-1:MW];
      sticky = |sh_wide[MW-1:0];
    end
    sml_al = sml_sh | {{(MW-1){1'b0}}, sticky};
    do_sub = isOpSub_i ^ (s_op1_i ^ s_op2_i);
    s2_eff = s_op2_i ^ isOpSub_i;
    // Larger minus smaller never goes negative, so the sum is already a magnitude
    sum    = big_m + (do_sub ? (~sml_al + MW'(1)) : sml_al);

    s1_calc          = '0;
    s1_calc.sign     = op1_gt ? s_op1_i : s2_eff;
    s1_calc.e        = big_e[E_DW-1:0];
    s1_calc.f        = sum;
    s1_calc.lzc      = lzc_f(sum[MW-2:0]);
    s1_calc.do_sub   = do_sub;
    s1_calc.nan      = isSNAN_op1_i | isQNAN_op1_i | isSNAN_op2_i | isQNAN_op2_i;
    s1_calc.snan     = isSNAN_op1_i | isSNAN_op2_i;
    s1_calc.inf_inf  = isInf_op1_i & isInf_op2_i & do_sub;
    s1_calc.inf      = isInf_op1_i | isInf_op2_i;
    s1_calc.inf_sign = isInf_op1_i ? s_op1_i : s2_eff;
    s1_calc.tag      = tag_i;
  end

  // Stage 2: normalise the registered sum, then let special operands override the result
  always_comb begin
    n_s   = s1_q.sign;
    n_e   = s1_q.e;
    n_f   = s1_q.f;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    n_inv = 1'b0;
    n_rnd = 1'b1;
    lsh   = '0;
    if (s1_q.f[MW-1]) begin
      // Carry out of the hidden position
      if (s1_q.e + E_DW'(1) == E_MAX) begin
        n_ovf = 1'b1;
        n_e   = E_MAX;
        n_f   = '0;
      end else begin
        n_f = {1'b0, s1_q.f[MW-1:2], s1_q.f[1] | s1_q.f[0]};
        n_e = s1_q.e + E_DW'(1);
      end
    end else if (s1_q.f[MW-2]) begin
      // Already normalised; R is only needed as part of sticky
      n_f = {s1_q.f[MW-1:2], 1'b0, s1_q.f[1] | s1_q.f[0]};
    end else if (s1_q.f == '0) begin
      // Exact zero is +0 unless both addends were negative zeros
      n_e = '0;
      n_f = '0;
      n_s = !s1_q.do_sub & s1_q.sign;
    end else if (s1_q.e > E_DW'(s1_q.lzc)) begin
      n_f = s1_q.f << s1_q.lzc;
      n_e = s1_q.e - E_DW'(s1_q.lzc);
    end else begin
      // Exponent would go below the minimum: result is denormal
      lsh   = (s1_q.e == '0) ? '0 : s1_q.e - E_DW'(1);
      n_e   = '0;
      n_unf = 1'b1;
`ifdef LAMP_FPU_ADDSUB_FTZ_EN
      n_f   = '0;
      n_rnd = 1'b0;
`else
      n_f   = s1_q.f << lsh;
`endif
    end

    if (s1_q.nan) begin
      n_s = 1'b0; n_e = E_MAX; n_f = QNAN_F;
      n_ovf = 1'b0; n_unf = 1'b0; n_inv = s1_q.snan; n_rnd = 1'b0;
    end else if (s1_q.inf_inf) begin
      n_s = 1'b0; n_e = E_MAX; n_f = QNAN_F;
      n_ovf = 1'b0; n_unf = 1'b0; n_inv = 1'b1; n_rnd = 1'b0;
    end else if (s1_q.inf) begin
      n_s = s1_q.inf_sign; n_e = E_MAX; n_f = '0;
      n_ovf = 1'b0; n_unf = 1'b0; n_inv = 1'b0; n_rnd = 1'b0;
    end

    res_calc     = '0;
    res_calc.s   = n_s;
    res_calc.e   = n_e;
    res_calc.f   = n_f;
    res_calc.ovf = n_ovf;
    res_calc.unf = n_unf;
    res_calc.inv = n_inv;
    res_calc.rnd = n_rnd;
    res_calc.tag = s1_q.tag;
  end

  // Pipeline control: each stage loads when its successor is empty or draining this cycle
  always_comb begin
    s2_advance  = !out_valid_q || out_ready_i;
    in_ready_o  = !s1_valid_q || s2_advance;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) s1_d = s1_calc;
    end
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) res_d = res_calc;
    end
  end

  // Stage registers; reset drops any in-flight beats and clears the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign s_res_o       = res_q.s;
  assign e_res_o       = res_q.e;
  assign f_res_o       = res_q.f;
  assign isOverflow_o  = res_q.ovf;
  assign isUnderflow_o = res_q.unf;
  assign isInvalid_o   = res_q.inv;
  assign isToRound_o   = res_q.rnd;
  assign tag_o         = res_q.tag;

endmodule

// File: tb/tb_lamp_fpu_addsub_pipe.sv
// Directed bench for lamp_fpu_addsub_pipe with bf16 default parameters.
// Result vectors are {s, e[7:0], f[11:0], ovf, unf, inv, toRound}.
module tb_lamp_fpu_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready_o, isOpSub, s_op1, s_op2;
  logic [7:0]  extF_op1, extF_op2;
  logic [8:0]  extE_op1, extE_op2;
  logic        isInf_op1, isSNAN_op1, isQNAN_op1, isInf_op2, isSNAN_op2, isQNAN_op2;
  logic [3:0]  tag_i, tag_o;
  logic        out_valid_o, out_ready;
  logic        s_res_o, isOverflow_o, isUnderflow_o, isInvalid_o, isToRound_o;
  logic [7:0]  e_res_o;
  logic [11:0] f_res_o;

  int          checks = 0;
  int          failures = 0;
  logic [24:0] r_vec;
  logic [3:0]  r_tag;
  int          r_lat;

  always #5 clk = ~clk;

  lamp_fpu_addsub_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .isOpSub_i(isOpSub),
    .s_op1_i(s_op1), .s_op2_i(s_op2),
    .extF_op1_i(extF_op1), .extF_op2_i(extF_op2),
    .extE_op1_i(extE_op1), .extE_op2_i(extE_op2),
    .isInf_op1_i(isInf_op1), .isSNAN_op1_i(isSNAN_op1), .isQNAN_op1_i(isQNAN_op1),
    .isInf_op2_i(isInf_op2), .isSNAN_op2_i(isSNAN_op2), .isQNAN_op2_i(isQNAN_op2),
    .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o),
    .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o),
    .isInvalid_o(isInvalid_o), .isToRound_o(isToRound_o), .tag_o(tag_o)
  );

  // Drive one beat (called at posedge+1), wait for its result, capture it, let it drain.
  // cls = {inf1, snan1, qnan1, inf2, snan2, qnan2}
  task automatic run_op(input logic sub, input logic sa, input logic [8:0] ea, input logic [7:0] fa,
                        input logic sb, input logic [8:0] eb, input logic [7:0] fb,
                        input logic [5:0] cls, input logic [3:0] tg);
    int n;
    isOpSub = sub; s_op1 = sa; extE_op1 = ea; extF_op1 = fa;
    s_op2 = sb; extE_op2 = eb; extF_op2 = fb;
    {isInf_op1, isSNAN_op1, isQNAN_op1, isInf_op2, isSNAN_op2, isQNAN_op2} = cls;
    tag_i = tg; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready_o && n < 20) begin @(posedge clk); #2; n++; end
    if (!in_ready_o) begin
      checks++; failures++;
      $display("FAIL accept_timeout tag=%0d in_ready=%b required=1", tg, in_ready_o);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    if (!out_valid_o) begin
      checks++; failures++;
      $display("FAIL result_timeout tag=%0d out_valid=%b required=1", tg, out_valid_o);
    end
    r_vec = {s_res_o, e_res_o, f_res_o, isOverflow_o, isUnderflow_o, isInvalid_o, isToRound_o};
    r_tag = tag_o;
    r_lat = n;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      failures++; $display("FAIL reset_hs got={ov,ir}=%b required=01", {out_valid_o, in_ready_o});
    end
    checks++;
    if ({s_res_o, e_res_o, f_res_o, isOverflow_o, isUnderflow_o, isInvalid_o, isToRound_o, tag_o} !== 29'd0) begin
      failures++; $display("FAIL reset_outputs got=%h required=0",
        {s_res_o, e_res_o, f_res_o, isOverflow_o, isUnderflow_o, isInvalid_o, isToRound_o, tag_o});
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      failures++; $display("FAIL reset_after_hs got={ov,ir}=%b required=01", {out_valid_o, in_ready_o});
    end
  endtask

  task automatic test_add_basic();
    logic [24:0] exp_v;
    run_op(0, 0, 9'h07F, 8'h80, 0, 9'h07F, 8'h80, 6'b0, 4'h5);   // 1.0 + 1.0
    exp_v = {1'b0, 8'h80, 12'h400, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL add_1p1 got=%h required=%h", r_vec, exp_v); end
    checks++;
    if (r_tag !== 4'h5) begin failures++; $display("FAIL add_tag got=%h required=5", r_tag); end
    checks++;
    if (r_lat !== 2) begin failures++; $display("FAIL add_latency got=%0d required=2", r_lat); end
    run_op(0, 0, 9'h07F, 8'hC0, 0, 9'h07F, 8'hC0, 6'b0, 4'h6);   // 1.5 + 1.5 = 3.0
    exp_v = {1'b0, 8'h80, 12'h600, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL add_1p5 got=%h required=%h", r_vec, exp_v); end
  endtask

  task automatic test_zero();
    logic [24:0] exp_v;
    run_op(1, 0, 9'h07F, 8'h80, 0, 9'h07F, 8'h80, 6'b0, 4'h1);   // 1.0 - 1.0
    exp_v = {1'b0, 8'h00, 12'h000, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL sub_1m1 got=%h required=%h", r_vec, exp_v); end
    run_op(0, 1, 9'h000, 8'h00, 1, 9'h000, 8'h00, 6'b0, 4'h2);   // -0 + -0
    exp_v = {1'b1, 8'h00, 12'h000, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL negz_add got=%h required=%h", r_vec, exp_v); end
    run_op(1, 1, 9'h000, 8'h00, 0, 9'h000, 8'h00, 6'b0, 4'h3);   // -0 - +0
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL negz_sub got=%h required=%h", r_vec, exp_v); end
    run_op(0, 0, 9'h000, 8'h00, 1, 9'h000, 8'h00, 6'b0, 4'h4);   // +0 + -0
    exp_v = {1'b0, 8'h00, 12'h000, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL mixz_add got=%h required=%h", r_vec, exp_v); end
  endtask

  task automatic test_overflow();
    logic [24:0] exp_v;
    run_op(0, 0, 9'h0FE, 8'hFF, 0, 9'h0FE, 8'hFF, 6'b0, 4'h7);
    exp_v = {1'b0, 8'hFF, 12'h000, 4'b1001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL overflow got=%h required=%h", r_vec, exp_v); end
  endtask

  task automatic test_specials();
    logic [24:0] exp_v;
    run_op(1, 0, 9'h0FF, 8'h80, 0, 9'h0FF, 8'h80, 6'b100100, 4'h8);   // +Inf - +Inf
    exp_v = {1'b0, 8'hFF, 12'h200, 4'b0010};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL inf_m_inf got=%h required=%h", r_vec, exp_v); end
    run_op(0, 1, 9'h0FF, 8'h80, 0, 9'h0FF, 8'h80, 6'b100100, 4'h8);   // -Inf + +Inf
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL ninf_p_inf got=%h required=%h", r_vec, exp_v); end
    run_op(0, 0, 9'h0FF, 8'h81, 0, 9'h07F, 8'h80, 6'b010000, 4'h9);   // SNAN + 1.0
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL snan_add got=%h required=%h", r_vec, exp_v); end
    run_op(0, 0, 9'h07F, 8'h80, 0, 9'h0FF, 8'hC0, 6'b000001, 4'h9);   // 1.0 + QNAN
    exp_v = {1'b0, 8'hFF, 12'h200, 4'b0000};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL qnan_add got=%h required=%h", r_vec, exp_v); end
    run_op(0, 0, 9'h0FF, 8'h80, 0, 9'h07F, 8'h80, 6'b100000, 4'hA);   // +Inf + 1.0
    exp_v = {1'b0, 8'hFF, 12'h000, 4'b0000};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL inf_p_one got=%h required=%h", r_vec, exp_v); end
    run_op(1, 0, 9'h07F, 8'h80, 0, 9'h0FF, 8'h80, 6'b000100, 4'hA);   // 1.0 - +Inf
    exp_v = {1'b1, 8'hFF, 12'h000, 4'b0000};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL one_m_inf got=%h required=%h", r_vec, exp_v); end
  endtask

  task automatic test_align();
    logic [24:0] exp_v;
    exp_v = {1'b0, 8'h7F, 12'h401, 4'b0001};
    run_op(0, 0, 9'h07F, 8'h80, 0, 9'h073, 8'h80, 6'b0, 4'hB);   // 1.0 + 2^-12
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL align_d12 got=%h required=%h", r_vec, exp_v); end
    run_op(0, 0, 9'h07F, 8'h80, 0, 9'h074, 8'h80, 6'b0, 4'hB);   // 1.0 + 2^-11 (limit)
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL align_d11 got=%h required=%h", r_vec, exp_v); end
    run_op(0, 0, 9'h07F, 8'h80, 0, 9'h076, 8'h80, 6'b0, 4'hB);   // 1.0 + 2^-9: R folds into S
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL align_d9 got=%h required=%h", r_vec, exp_v); end
    run_op(1, 0, 9'h07F, 8'h80, 0, 9'h073, 8'h80, 6'b0, 4'hB);   // 1.0 - 2^-12
    exp_v = {1'b0, 8'h7E, 12'h7FE, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL align_sub got=%h required=%h", r_vec, exp_v); end
  endtask

  task automatic test_normalise();
    logic [24:0] exp_v;
    run_op(1, 0, 9'h07F, 8'h80, 0, 9'h07E, 8'hC0, 6'b0, 4'hC);   // 1.0 - 0.75 = 0.25
    exp_v = {1'b0, 8'h7D, 12'h400, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL norm_lzc2 got=%h required=%h", r_vec, exp_v); end
    run_op(1, 0, 9'h07F, 8'h80, 0, 9'h080, 8'h80, 6'b0, 4'hC);   // 1.0 - 2.0 = -1.0
    exp_v = {1'b1, 8'h7F, 12'h400, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL norm_neg got=%h required=%h", r_vec, exp_v); end
    run_op(1, 0, 9'h002, 8'hC0, 0, 9'h002, 8'h80, 6'b0, 4'hD);   // lands on min normal
    exp_v = {1'b0, 8'h01, 12'h400, 4'b0001};
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL norm_minnorm got=%h required=%h", r_vec, exp_v); end
    run_op(1, 0, 9'h001, 8'hC0, 0, 9'h001, 8'h80, 6'b0, 4'hD);   // denormal result
`ifdef LAMP_FPU_ADDSUB_FTZ_EN
    exp_v = {1'b0, 8'h00, 12'h000, 4'b0100};
`else
    exp_v = {1'b0, 8'h00, 12'h200, 4'b0101};
`endif
    checks++;
    if (r_vec !== exp_v) begin failures++; $display("FAIL norm_denorm got=%h required=%h", r_vec, exp_v); end
  endtask

  task automatic test_back_to_back();
    int cyc, sent, got;
    logic in_fire, hold, saw_low;
    logic [24:0] snap;
    logic [3:0]  g_tag [4];
    logic [7:0]  g_e   [4];
    logic [11:0] g_f   [4];
    cyc = 0; sent = 0; got = 0; saw_low = 1'b0; hold = 1'b0; snap = '0;
    isOpSub = 0; s_op1 = 0; s_op2 = 0; extF_op1 = 8'h80; extF_op2 = 8'h80;
    {isInf_op1, isSNAN_op1, isQNAN_op1, isInf_op2, isSNAN_op2, isQNAN_op2} = 6'b0;
    extE_op1 = 9'h07F; extE_op2 = 9'h07F; tag_i = 4'd0;
    out_ready = 1'b1; in_valid = 1'b1;
    while (got < 4 && cyc < 60) begin
      #1;
      in_fire = in_valid && in_ready_o;
      if (in_valid && !in_ready_o) saw_low = 1'b1;
      if (out_valid_o && out_ready) begin
        g_tag[got] = tag_o; g_e[got] = e_res_o; g_f[got] = f_res_o; got++;
      end
      hold = out_valid_o && !out_ready;
      snap = {tag_o, s_res_o, e_res_o, f_res_o};
      @(posedge clk); #1;
      cyc++;
      if (hold) begin
        checks++;
        if ({tag_o, s_res_o, e_res_o, f_res_o} !== snap || out_valid_o !== 1'b1) begin
          failures++; $display("FAIL b2b_hold cyc=%0d got=%h v=%b required=%h v=1",
                               cyc, {tag_o, s_res_o, e_res_o, f_res_o}, out_valid_o, snap);
        end
      end
      if (in_fire) begin
        sent++;
        if (sent < 4) begin
          tag_i = 4'(sent); extE_op1 = 9'h07F + 9'(sent); extE_op2 = 9'h07F + 9'(sent);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = !(cyc >= 2 && cyc <= 5);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 4) begin failures++; $display("FAIL b2b_count got=%0d required=4", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if ({g_tag[i], g_e[i], g_f[i]} !== {4'(i), 8'h80 + 8'(i), 12'h400}) begin
        failures++; $display("FAIL b2b_beat%0d got=%h required=%h", i,
                             {g_tag[i], g_e[i], g_f[i]}, {4'(i), 8'h80 + 8'(i), 12'h400});
      end
    end
    checks++;
    if (saw_low !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_drop got=%b required=1", saw_low); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_extra cyc=%0d out_valid=%b required=0", i, out_valid_o); end
    end
  endtask

  task automatic test_reset_midflight();
    isOpSub = 0; s_op1 = 0; s_op2 = 0; extE_op1 = 9'h07F; extE_op2 = 9'h07F;
    extF_op1 = 8'h80; extF_op2 = 8'h80;
    {isInf_op1, isSNAN_op1, isQNAN_op1, isInf_op2, isSNAN_op2, isQNAN_op2} = 6'b0;
    out_ready = 1'b0; in_valid = 1'b1; tag_i = 4'hA;
    @(posedge clk); #1;
    tag_i = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b10) begin
      failures++; $display("FAIL rstmid_full got={ov,ir}=%b required=10", {out_valid_o, in_ready_o});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      failures++; $display("FAIL rstmid_cleared got={ov,ir}=%b required=01", {out_valid_o, in_ready_o});
    end
    checks++;
    if ({e_res_o, f_res_o, tag_o} !== 24'd0) begin
      failures++; $display("FAIL rstmid_outputs got=%h required=0", {e_res_o, f_res_o, tag_o});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b0) begin
        failures++; $display("FAIL rstmid_leak cyc=%0d out_valid=%b tag=%h required valid=0", i, out_valid_o, tag_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; isOpSub = 1'b0;
    s_op1 = 1'b0; s_op2 = 1'b0; extE_op1 = '0; extE_op2 = '0; extF_op1 = '0; extF_op2 = '0;
    {isInf_op1, isSNAN_op1, isQNAN_op1, isInf_op2, isSNAN_op2, isQNAN_op2} = 6'b0;
    tag_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_add_basic();
    test_zero();
    test_overflow();
    test_specials();
    test_align();
    test_normalise();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
